// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control sequencer and its ALU decoder.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNC  = 2'b10,
    ALUOP_PASSB = 2'b11
  } aluop_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_SRL   = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Store width strobe from func3: sb/sh/sw -> 01/10/11, anything else none.
  function automatic logic [1:0] store_width(input logic [2:0] func3);
    case (func3)
      3'b000:  store_width = 2'b01;
      3'b001:  store_width = 2'b10;
      3'b010:  store_width = 2'b11;
      default: store_width = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ALU control decode from ALUOp class plus instruction function fields.
// Latency: purely combinational.
// Backpressure: none.
// Ports: alu_op (class), func3, op5 (opcode[5]), func7_5 -> alu_control.
module multicycle_ctrl_fsm_alu_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] func3,
  input  logic       op5,
  input  logic       func7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_PASSB: alu_control = ALU_PASSB;
      ALUOP_FUNC: begin
        case (func3)
          // Only R-type (op5=1) uses func7_5 as the sub selector; addi never subtracts.
          3'b000:  alu_control = (op5 && func7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle core sequencer: steps fetch/decode/execute/writeback and drives all datapath selects/strobes.
// Latency: 3 (branch) to 5 (load) cycles per instruction with memory ready every cycle.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold with all outputs stable until mem_ready.
// Ports: clk/rst; opcode/func3/func7_5/zero/mem_ready in; mem_req, adr_src, mem_write, ir_write,
//        pc_write, reg_write, result_src, alu_src_a/b, alu_control, instr_retired, illegal, state_o out.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic [1:0] mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       instr_retired,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  aluop_e alu_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= state_e'(RESET_STATE);
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD:           state_d = S_MEMADR;
          OP_STORE:          state_d = (func3 > 3'b010) ? S_TRAP : S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE, OP_LUI:  state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 2'b00;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Precompute branch/jal target into ALUOut while decode resolves.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src    = RES_RDATA;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        adr_src       = 1'b1;
        mem_write     = store_width(func3);
        instr_retired = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_LUI) ? ALUOP_PASSB : ALUOP_FUNC;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = SRCA_RS1;
        alu_op        = ALUOP_SUB;
        // func3[0] flips beq into bne.
        pc_write      = zero ^ func3[0];
        instr_retired = 1'b1;
      end
      S_JAL: begin
        // ALU forms OldPC+4 for rd while PC loads the target held in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // Reset holds state at FETCH; keep its mem_ready-qualified strobes quiet too.
    if (rst) begin
      mem_req       = 1'b0;
      mem_write     = 2'b00;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  multicycle_ctrl_fsm_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .func3       (func3),
    .op5         (opcode[5]),
    .func7_5     (func7_5),
    .alu_control (alu_control)
  );

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       adr_src;
  logic [1:0] mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       instr_retired;
  logic       illegal;
  logic [3:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .func3         (func3),
    .func7_5       (func7_5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .instr_retired (instr_retired),
    .illegal       (illegal),
    .state_o       (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check state and key strobes in the current cycle, then advance one clock.
  task automatic cyc(input string tag, input int st, input int rw, input int ret, input int pw);
    #1;
    chk({tag, ".state"},     32'(state_o),       st);
    chk({tag, ".reg_write"}, 32'(reg_write),     rw);
    chk({tag, ".retired"},   32'(instr_retired), ret);
    chk({tag, ".pc_write"},  32'(pc_write),      pw);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode  = op;
    func3   = f3;
    func7_5 = f75;
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;

  logic [6:0] alu_op_t [8] = '{R, I, R, I, R, I, R, LU};
  logic [2:0] alu_f3_t [8] = '{3'b000, 3'b000, 3'b100, 3'b111, 3'b101, 3'b010, 3'b110, 3'b000};
  logic       alu_f7_t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int         alu_exp  [8] = '{1, 0, 6, 2, 7, 5, 3, 4};
  int         alu_st   [8] = '{6, 7, 6, 7, 6, 7, 6, 7};

  logic [2:0] st_f3_t  [3] = '{3'b001, 3'b000, 3'b010};
  int         st_exp   [3] = '{2, 1, 3};

  logic [2:0] br_f3_t  [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
  logic       br_z_t   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int         br_pw    [4] = '{1, 0, 1, 0};

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    set_ir(R, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst.state",     32'(state_o),       0);
    chk("rst.mem_req",   32'(mem_req),       0);
    chk("rst.ir_write",  32'(ir_write),      0);
    chk("rst.pc_write",  32'(pc_write),      0);
    chk("rst.reg_write", 32'(reg_write),     0);
    chk("rst.retired",   32'(instr_retired), 0);
    chk("rst.mem_write", 32'(mem_write),     0);
    chk("rst.illegal",   32'(illegal),       0);
    rst = 1'b0;

    // Fetch stall then add x3,x1,x2
    mem_ready = 1'b0;
    #1;
    chk("fstall.ir_write", 32'(ir_write), 0);
    chk("fstall.mem_req",  32'(mem_req),  1);
    cyc("fstall.F", 0, 0, 0, 0);
    mem_ready = 1'b1;
    #1;
    chk("add.F.ir_write", 32'(ir_write),   1);
    chk("add.F.src_b",    32'(alu_src_b),  2);
    chk("add.F.res",      32'(result_src), 2);
    chk("add.F.adr_src",  32'(adr_src),    0);
    cyc("add.F", 0, 0, 0, 1);
    cyc("add.D", 1, 0, 0, 0);
    #1;
    chk("add.X.alu", 32'(alu_control), 0);
    chk("add.X.src_a", 32'(alu_src_a), 2);
    chk("add.X.src_b", 32'(alu_src_b), 0);
    cyc("add.X", 6, 0, 0, 0);
    #1;
    chk("add.WB.res", 32'(result_src), 0);
    cyc("add.WB", 8, 1, 1, 0);

    for (int i = 0; i < 8; i++) begin
      set_ir(alu_op_t[i], alu_f3_t[i], alu_f7_t[i]);
      cyc("alu.F", 0, 0, 0, 1);
      cyc("alu.D", 1, 0, 0, 0);
      #1;
      chk($sformatf("alu%0d.ctrl", i), 32'(alu_control), alu_exp[i]);
      cyc("alu.X", alu_st[i], 0, 0, 0);
      cyc("alu.WB", 8, 1, 1, 0);
    end

    // lw with three wait cycles in MEMREAD
    set_ir(LD, 3'b010, 1'b0);
    cyc("lw.F", 0, 0, 0, 1);
    cyc("lw.D", 1, 0, 0, 0);
    #1;
    chk("lw.MA.src_a", 32'(alu_src_a), 2);
    chk("lw.MA.src_b", 32'(alu_src_b), 1);
    mem_ready = 1'b0;
    cyc("lw.MA", 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw.MR.adr_src", 32'(adr_src), 1);
      chk("lw.MR.mem_req", 32'(mem_req), 1);
      cyc("lw.MRwait", 3, 0, 0, 0);
    end
    mem_ready = 1'b1;
    cyc("lw.MR", 3, 0, 0, 0);
    #1;
    chk("lw.WB.res", 32'(result_src), 1);
    cyc("lw.WB", 4, 1, 1, 0);

    // stores: sh, sb, sw with one wait cycle each
    for (int i = 0; i < 3; i++) begin
      set_ir(ST, st_f3_t[i], 1'b0);
      cyc("st.F", 0, 0, 0, 1);
      cyc("st.D", 1, 0, 0, 0);
      #1;
      chk("st.MA.mem_write", 32'(mem_write), 0);
      cyc("st.MA", 2, 0, 0, 0);
      mem_ready = 1'b0;
      #1;
      chk($sformatf("st%0d.wait.mem_write", i), 32'(mem_write), st_exp[i]);
      chk("st.wait.adr_src", 32'(adr_src), 1);
      cyc("st.MWwait", 5, 0, 0, 0);
      mem_ready = 1'b1;
      #1;
      chk($sformatf("st%0d.mem_write", i), 32'(mem_write), st_exp[i]);
      cyc("st.MW", 5, 0, 1, 0);
      #1;
      chk("st.F.mem_write", 32'(mem_write), 0);
    end

    // branches: beq taken/not, bne taken/not
    for (int i = 0; i < 4; i++) begin
      set_ir(BR, br_f3_t[i], 1'b0);
      zero = br_z_t[i];
      cyc("br.F", 0, 0, 0, 1);
      cyc("br.D", 1, 0, 0, 0);
      #1;
      chk("br.alu", 32'(alu_control), 1);
      cyc($sformatf("br%0d", i), 9, 0, 1, br_pw[i]);
    end
    zero = 1'b0;

    // jal
    set_ir(JL, 3'b000, 1'b0);
    cyc("jal.F", 0, 0, 0, 1);
    cyc("jal.D", 1, 0, 0, 0);
    #1;
    chk("jal.src_a", 32'(alu_src_a), 1);
    chk("jal.src_b", 32'(alu_src_b), 2);
    chk("jal.res",   32'(result_src), 0);
    cyc("jal.J", 10, 0, 0, 1);
    #1;
    chk("jal.WB.res", 32'(result_src), 0);
    cyc("jal.WB", 8, 1, 1, 0);

    // async reset in the middle of a stalled load
    set_ir(LD, 3'b010, 1'b0);
    cyc("ar.F", 0, 0, 0, 1);
    cyc("ar.D", 1, 0, 0, 0);
    mem_ready = 1'b0;
    cyc("ar.MA", 2, 0, 0, 0);
    cyc("ar.MR", 3, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.state",     32'(state_o),   0);
    chk("ar.mem_req",   32'(mem_req),   0);
    chk("ar.reg_write", 32'(reg_write), 0);
    mem_ready = 1'b1;
    #1;
    chk("ar.ir_write", 32'(ir_write), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    cyc("ar.F2", 0, 0, 0, 1);
    cyc("ar.D2", 1, 0, 0, 0);
    cyc("ar.MA2", 2, 0, 0, 0);
    cyc("ar.MR2", 3, 0, 0, 0);
    cyc("ar.WB2", 4, 1, 1, 0);

    // store with unsupported width traps and sticks
    set_ir(ST, 3'b011, 1'b0);
    cyc("trap.F", 0, 0, 0, 1);
    cyc("trap.D", 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("trap.illegal", 32'(illegal), 1);
      chk("trap.mem_req", 32'(mem_req), 0);
      cyc("trap.T", 11, 0, 0, 0);
    end
    rst = 1'b1;
    #1;
    chk("trap.rst.illegal", 32'(illegal), 0);
    chk("trap.rst.state",   32'(state_o), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // unknown opcode traps
    set_ir(7'b0000000, 3'b000, 1'b0);
    cyc("badop.F", 0, 0, 0, 1);
    cyc("badop.D", 1, 0, 0, 0);
    #1;
    chk("badop.illegal", 32'(illegal), 1);
    cyc("badop.T", 11, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
